// File: rtl/code_rom_loader.sv
// code_rom_loader: streams host bytes into the debug harness code ROM.
// After the final host byte the loader pads to a 4-byte instruction
// boundary with END_FILL and appends one END_FILL end instruction.
// Optional feature: define CODE_ROM_LOADER_CHECKSUM_EN to build the
// running modulo-256 checksum of accepted program bytes; otherwise the
// checksum port is tied to zero.
module code_rom_loader #(
    parameter int         NUM_BYTES = 64,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] END_FILL  = 8'hFF
) (
    input  logic              hclk,
    input  logic              reset_code_rom_n,
    input  logic              start,
    input  logic              abort,
    input  logic              host_valid,
    input  logic [7:0]        host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic              rom_prog_mode,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_wr_strobe,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   byte_count,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0] CAPACITY = (ADDR_W+1)'(NUM_BYTES);
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_END,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [ADDR_W:0] addr;
    logic [ADDR_W:0] addr_inc;
    logic            accept;
    logic            fill_write;
    logic            wr_next;
    logic [7:0]      wr_data;
    logic            load_start;

    assign addr_inc = addr + ONE;

    // State register; reset returns the loader to IDLE at once
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) next_state = S_LOAD;
            end
            S_LOAD: begin
                if (accept && host_last) begin
                    next_state = (addr_inc[1:0] == 2'b00) ? S_END : S_PAD;
                end else if (host_valid && !host_ready) begin
                    next_state = S_ERROR;
                end
            end
            S_PAD: begin
                if (addr[1:0] == 2'b11) next_state = S_END;
            end
            S_END: begin
                if (addr[1:0] == 2'b11) next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    // Handshake and write selection: host bytes in LOAD, fill bytes in PAD/END
    always_comb begin
        host_ready = (state == S_LOAD) && (addr < CAPACITY);
        accept     = host_ready && host_valid;
        fill_write = (state == S_PAD) || (state == S_END);
        wr_next    = !abort && (accept || fill_write);
        wr_data    = accept ? host_data : END_FILL;
        load_start = !abort && start &&
                     ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    end

    // Registered ROM port, address counter and status; the write presented
    // in the last END cycle keeps program mode high so the harness captures it
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            addr          <= '0;
            rom_addr      <= '0;
            rom_data      <= END_FILL;
            rom_wr_strobe <= 1'b0;
            rom_prog_mode <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            byte_count    <= '0;
        end else begin
            rom_wr_strobe <= wr_next;
            rom_prog_mode <= wr_next ||
                             (next_state inside {S_LOAD, S_PAD, S_END});
            load_done     <= (next_state == S_DONE) && !wr_next;
            load_error    <= (next_state == S_ERROR);
            if (load_start) begin
                addr       <= '0;
                byte_count <= '0;
                rom_addr   <= '0;
                rom_data   <= END_FILL;
            end else if (wr_next) begin
                rom_addr <= addr[ADDR_W-1:0];
                rom_data <= wr_data;
                addr     <= addr_inc;
                if (accept) byte_count <= byte_count + ONE;
            end
        end
    end

`ifdef CODE_ROM_LOADER_CHECKSUM_EN
    // Running sum of accepted program bytes; fill bytes are excluded
    always_ff @(posedge hclk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            checksum <= 8'h00;
        end else if (load_start) begin
            checksum <= 8'h00;
        end else if (accept && !abort) begin
            checksum <= checksum + host_data;
        end
    end
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_code_rom_loader.sv
// Self-checking bench for code_rom_loader: random programs are streamed
// in and the captured ROM image is compared with the image implied by
// the padding rules (program bytes, fill to a 4-byte boundary, 4 end bytes).
module tb_code_rom_loader;

    localparam int         NUM_BYTES = 64;
    localparam int         ADDR_W    = 12;
    localparam logic [7:0] FILL      = 8'hFF;
    localparam int         IMG_SIZE  = NUM_BYTES + 8;

    logic              hclk;
    logic              reset_code_rom_n;
    logic              start;
    logic              abort;
    logic              host_valid;
    logic [7:0]        host_data;
    logic              host_last;
    logic              host_ready;
    logic              rom_prog_mode;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rom_wr_strobe;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   byte_count;
    logic [7:0]        checksum;

    code_rom_loader #(
        .NUM_BYTES (NUM_BYTES),
        .ADDR_W    (ADDR_W),
        .END_FILL  (FILL)
    ) dut (
        .hclk             (hclk),
        .reset_code_rom_n (reset_code_rom_n),
        .start            (start),
        .abort            (abort),
        .host_valid       (host_valid),
        .host_data        (host_data),
        .host_last        (host_last),
        .host_ready       (host_ready),
        .rom_prog_mode    (rom_prog_mode),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .rom_wr_strobe    (rom_wr_strobe),
        .load_done        (load_done),
        .load_error       (load_error),
        .byte_count       (byte_count),
        .checksum         (checksum)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int         check_count = 0;
    int         error_count = 0;
    logic [7:0] prog_data [0:NUM_BYTES];
    logic [7:0] rom_img   [0:IMG_SIZE-1];
    bit         written   [0:IMG_SIZE-1];
    int         wr_count;
    int         stray_writes;
    int         bad_mode_writes;
    int         cycle = 0;
    int         last_strobe_cycle;
    int         done_cycle;
    logic       prev_done = 1'b0;

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Cycle counter used to relate the done edge to the last write
    always @(posedge hclk) cycle++;

    // Harness ROM stand-in: captures every presented write
    always @(negedge hclk) begin
        if (rom_wr_strobe) begin
            wr_count++;
            last_strobe_cycle = cycle;
            if (!rom_prog_mode) bad_mode_writes++;
            if (int'(rom_addr) < IMG_SIZE) begin
                rom_img[rom_addr] = rom_data;
                written[rom_addr] = 1'b1;
            end else begin
                stray_writes++;
            end
        end
        if (load_done && !prev_done) done_cycle = cycle;
        prev_done = load_done;
    end

    task automatic clearCapture();
        for (int a = 0; a < IMG_SIZE; a++) begin
            rom_img[a] = 8'h00;
            written[a] = 1'b0;
        end
        wr_count          = 0;
        stray_writes      = 0;
        bad_mode_writes   = 0;
        last_strobe_cycle = -1;
        done_cycle        = -1;
    endtask

    task automatic randomProgram(input int len);
        for (int i = 0; i < len; i++) prog_data[i] = 8'($urandom);
    endtask

    // Start pulse; the loader must be ready one cycle later
    task automatic pulseStart();
        start = 1'b1;
        @(posedge hclk); #1;
        start = 1'b0;
        checkOutput("startMode", rom_prog_mode, 1);
        checkOutput("startReady", host_ready, 1);
    endtask

    // Streams prog_data[0..len-1]; optional random stalls and one fixed
    // 3-cycle stall before byte stall_at, during which the port must hold
    task automatic applyStimulus(input int len, input int stall_pct,
                                 input int stall_at, input bit with_last);
        int waits;
        int n;
        for (int i = 0; i < len; i++) begin
            if (i == stall_at && i > 0) begin
                for (int s = 0; s < 3; s++) begin
                    @(posedge hclk); #1;
                    checkOutput("stallStrobe", rom_wr_strobe, 0);
                    checkOutput("stallAddr", rom_addr, i - 1);
                    checkOutput("stallData", rom_data, prog_data[i-1]);
                end
            end else begin
                n = ($urandom_range(99) < stall_pct) ? $urandom_range(3, 1) : 0;
                repeat (n) begin
                    @(posedge hclk); #1;
                end
            end
            host_valid = 1'b1;
            host_data  = prog_data[i];
            host_last  = with_last && (i == len - 1);
            @(negedge hclk);
            waits = 0;
            while (!host_ready && waits < 10) begin
                @(negedge hclk);
                waits++;
            end
            if (!host_ready) checkOutput("readyTimeout", 0, 1);
            @(posedge hclk); #1;
            host_valid = 1'b0;
            host_last  = 1'b0;
        end
    endtask

    task automatic waitFinish();
        int waits = 0;
        while (!load_done && !load_error && waits < 100) begin
            @(negedge hclk);
            waits++;
        end
        @(posedge hclk); #1;
        checkOutput("doneLevel", load_done, 1);
    endtask

    // Compares the captured image and status with the padding rules
    task automatic verifyLoad(input int len);
        int         padded = ((len + 3) / 4) * 4;
        int         total  = padded + 4;
        int         bad    = 0;
        logic [7:0] sum    = 8'h00;
        logic [7:0] exp_v;
        for (int a = 0; a < IMG_SIZE; a++) begin
            exp_v = (a < len) ? prog_data[a] : FILL;
            if (written[a] != (a < total)) bad++;
            else if (a < total && rom_img[a] !== exp_v) bad++;
        end
        for (int i = 0; i < len; i++) sum = sum + prog_data[i];
`ifndef CODE_ROM_LOADER_CHECKSUM_EN
        sum = 8'h00;
`endif
        checkOutput("imageBadBytes", bad, 0);
        checkOutput("writeCount", wr_count, total);
        checkOutput("strayWrites", stray_writes, 0);
        checkOutput("writesOutsideMode", bad_mode_writes, 0);
        checkOutput("byteCount", byte_count, len);
        checksum_check: checkOutput("checksum", checksum, sum);
        checkOutput("errorLevel", load_error, 0);
        checkOutput("modeAfterDone", rom_prog_mode, 0);
        checkOutput("doneAfterLastWrite", done_cycle, last_strobe_cycle + 1);
    endtask

    initial begin
        reset_code_rom_n = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        host_valid       = 1'b0;
        host_data        = 8'h00;
        host_last        = 1'b0;
        clearCapture();
        #12;
        checkOutput("rstReady", host_ready, 0);
        checkOutput("rstMode", rom_prog_mode, 0);
        checkOutput("rstAddr", rom_addr, 0);
        checkOutput("rstData", rom_data, FILL);
        checkOutput("rstStrobe", rom_wr_strobe, 0);
        checkOutput("rstDone", load_done, 0);
        checkOutput("rstError", load_error, 0);
        checkOutput("rstCount", byte_count, 0);
        checkOutput("rstChecksum", checksum, 0);
        @(posedge hclk); #1;
        reset_code_rom_n = 1'b1;
        @(posedge hclk); #1;

        // 8-byte program 01..08: one full instruction pair plus end
        clearCapture();
        for (int i = 0; i < 8; i++) prog_data[i] = 8'(i + 1);
        pulseStart();
        checkOutput("firstAddr", rom_addr, 0);
        checkOutput("firstData", rom_data, FILL);
        applyStimulus(8, 0, -1, 1'b1);
        waitFinish();
        verifyLoad(8);
`ifdef CODE_ROM_LOADER_CHECKSUM_EN
        checkOutput("checksum8", checksum, 8'h24);
`endif

        // 6-byte program with a 3-cycle host stall: two pad bytes
        clearCapture();
        randomProgram(6);
        pulseStart();
        applyStimulus(6, 0, 3, 1'b1);
        waitFinish();
        verifyLoad(6);

        // Full capacity with host_last on the final byte
        clearCapture();
        randomProgram(NUM_BYTES);
        pulseStart();
        applyStimulus(NUM_BYTES, 10, -1, 1'b1);
        waitFinish();
        verifyLoad(NUM_BYTES);

        // Overflow: a 65th byte without host_last is refused
        clearCapture();
        randomProgram(NUM_BYTES);
        pulseStart();
        applyStimulus(NUM_BYTES, 0, -1, 1'b0);
        host_valid = 1'b1;
        host_data  = 8'h5A;
        @(negedge hclk);
        checkOutput("overflowReady", host_ready, 0);
        @(posedge hclk); #1;
        host_valid = 1'b0;
        checkOutput("overflowError", load_error, 1);
        checkOutput("overflowMode", rom_prog_mode, 0);
        repeat (2) begin
            @(posedge hclk); #1;
        end
        checkOutput("overflowWrites", wr_count, NUM_BYTES);
        checkOutput("overflowAddr64", written[NUM_BYTES], 0);

        // Abort after byte 3, then a fresh load from address 0
        clearCapture();
        randomProgram(3);
        pulseStart();
        applyStimulus(3, 0, -1, 1'b0);
        abort = 1'b1;
        @(posedge hclk); #1;
        abort = 1'b0;
        checkOutput("abortMode", rom_prog_mode, 0);
        checkOutput("abortReady", host_ready, 0);
        checkOutput("abortError", load_error, 0);
        repeat (2) begin
            @(posedge hclk); #1;
        end
        checkOutput("abortWrites", wr_count, 3);
        clearCapture();
        randomProgram(5);
        pulseStart();
        applyStimulus(5, 20, -1, 1'b1);
        waitFinish();
        verifyLoad(5);

        // Reset mid-load: outputs return to reset values immediately
        clearCapture();
        randomProgram(3);
        pulseStart();
        applyStimulus(3, 0, -1, 1'b0);
        #2;
        reset_code_rom_n = 1'b0;
        #1;
        checkOutput("midRstMode", rom_prog_mode, 0);
        checkOutput("midRstAddr", rom_addr, 0);
        checkOutput("midRstData", rom_data, FILL);
        checkOutput("midRstCount", byte_count, 0);
        checkOutput("midRstReady", host_ready, 0);
        @(posedge hclk); #1;
        reset_code_rom_n = 1'b1;
        @(posedge hclk); #1;
        clearCapture();
        randomProgram(11);
        pulseStart();
        applyStimulus(11, 20, -1, 1'b1);
        waitFinish();
        verifyLoad(11);

        // Random lengths with random host stalls
        for (int t = 0; t < 10; t++) begin
            int len = $urandom_range(NUM_BYTES, 1);
            clearCapture();
            randomProgram(len);
            pulseStart();
            applyStimulus(len, 30, (len > 2) ? $urandom_range(len - 1, 1) : -1, 1'b1);
            waitFinish();
            verifyLoad(len);
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
